// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive sequencer.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_EOP_WAIT,
        ST_ERR_WAIT
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;
    localparam int         BYTE_BITS   = 8;

endpackage

// File: rtl/usb_rx_unstuff.sv
// Counts consecutive decoded ones and classifies each strobed bit as
// data, a stuffed zero to discard, or a stuff error.
module usb_rx_unstuff
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic strobe_i,
    input  logic d_i,
    output logic bit_take_o,
    output logic stuff_err_o
);

    logic [2:0] ones_q, ones_d;
    logic       at_limit;

    assign at_limit    = (ones_q == 3'(STUFF_LIMIT));
    assign bit_take_o  = strobe_i & ~at_limit;
    assign stuff_err_o = strobe_i & at_limit & d_i;

    always_comb begin
        ones_d = ones_q;
        if (clear_i) begin
            ones_d = 3'd0;
        end else if (strobe_i) begin
            // A stuffed zero (or an erroring one) restarts the run.
            if (at_limit || !d_i) begin
                ones_d = 3'd0;
            end else begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 3'd0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx_sequencer.sv
// USB 1.1 full-speed receive sequencer: SYNC/PID validation, unstuffing,
// byte assembly and packet error detection. Optional PID complement check
// is enabled by defining USB_RX_PID_CHECK_EN.
module usb_rx_sequencer
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       shift_enable,
    input  logic       d_orig,
    input  logic       eop,
    output logic       decode_clear,
    output logic       timer_enable,
    output logic       rcving,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       packet_done,
    output logic       r_error
);

    localparam int BCW = $clog2(MAX_BYTES + 1);

    rx_state_t      state_q;
    logic [7:0]     sr_q;
    logic [2:0]     bit_cnt_q;
    logic [BCW-1:0] byte_cnt_q;
    logic           seen_eop_q;
    logic [3:0]     rx_pid_q;
    logic [7:0]     rx_data_q;
    logic           pid_valid_q, rx_data_valid_q, packet_done_q, r_error_q;

    logic       in_rx, bit_take, stuff_err, last_bit;
    logic [7:0] sr_d;

    assign in_rx    = (state_q == ST_SYNC) || (state_q == ST_PID) || (state_q == ST_DATA);
    assign sr_d     = {d_orig, sr_q[7:1]};
    assign last_bit = (bit_cnt_q == 3'(BYTE_BITS - 1));

    usb_rx_unstuff u_unstuff (
        .clk         (clk),
        .rst         (rst),
        .clear_i     ((state_q == ST_IDLE) && d_edge),
        .strobe_i    (in_rx && shift_enable && !eop),
        .d_i         (d_orig),
        .bit_take_o  (bit_take),
        .stuff_err_o (stuff_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sr_q            <= 8'h00;
            bit_cnt_q       <= 3'd0;
            byte_cnt_q      <= '0;
            seen_eop_q      <= 1'b0;
            rx_pid_q        <= 4'h0;
            rx_data_q       <= 8'h00;
            pid_valid_q     <= 1'b0;
            rx_data_valid_q <= 1'b0;
            packet_done_q   <= 1'b0;
            r_error_q       <= 1'b0;
        end else begin
            pid_valid_q     <= 1'b0;
            rx_data_valid_q <= 1'b0;
            packet_done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (d_edge) begin
                        state_q    <= ST_SYNC;
                        sr_q       <= 8'h00;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= '0;
                        r_error_q  <= 1'b0;
                    end
                end
                ST_SYNC, ST_PID, ST_DATA: begin
                    if (eop) begin
                        if (state_q == ST_DATA && bit_cnt_q == 3'd0) begin
                            state_q <= ST_EOP_WAIT;
                        end else begin
                            state_q    <= ST_ERR_WAIT;
                            r_error_q  <= 1'b1;
                            seen_eop_q <= 1'b1;
                        end
                    end else if (stuff_err) begin
                        state_q    <= ST_ERR_WAIT;
                        r_error_q  <= 1'b1;
                        seen_eop_q <= 1'b0;
                    end else if (bit_take) begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (state_q == ST_SYNC) begin
                                if (sr_d == SYNC_BYTE) begin
                                    state_q <= ST_PID;
                                end else begin
                                    state_q    <= ST_ERR_WAIT;
                                    r_error_q  <= 1'b1;
                                    seen_eop_q <= 1'b0;
                                end
                            end else if (state_q == ST_PID) begin
`ifdef USB_RX_PID_CHECK_EN
                                if (sr_d[7:4] != ~sr_d[3:0]) begin
                                    state_q    <= ST_ERR_WAIT;
                                    r_error_q  <= 1'b1;
                                    seen_eop_q <= 1'b0;
                                end else begin
                                    rx_pid_q    <= sr_d[3:0];
                                    pid_valid_q <= 1'b1;
                                    state_q     <= ST_DATA;
                                end
`else
                                rx_pid_q    <= sr_d[3:0];
                                pid_valid_q <= 1'b1;
                                state_q     <= ST_DATA;
`endif
                            end else if (byte_cnt_q == BCW'(MAX_BYTES)) begin
                                // Oversized packet: the extra byte is never reported.
                                state_q    <= ST_ERR_WAIT;
                                r_error_q  <= 1'b1;
                                seen_eop_q <= 1'b0;
                            end else begin
                                rx_data_q       <= sr_d;
                                rx_data_valid_q <= 1'b1;
                                byte_cnt_q      <= byte_cnt_q + BCW'(1);
                            end
                        end
                    end
                end
                ST_EOP_WAIT: begin
                    if (!eop) begin
                        packet_done_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_ERR_WAIT: begin
                    if (eop) begin
                        seen_eop_q <= 1'b1;
                    end else if (seen_eop_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign decode_clear  = (state_q == ST_IDLE) || (state_q == ST_EOP_WAIT) ||
                           (state_q == ST_ERR_WAIT);
    assign timer_enable  = in_rx;
    assign rcving        = in_rx;
    assign rx_pid        = rx_pid_q;
    assign pid_valid     = pid_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;
    assign packet_done   = packet_done_q;
    assign r_error       = r_error_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer: drives decoded bit streams with a
// small transmit-side stuffing model and counts the output strobes.
module tb_usb_rx_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0, shift_enable = 1'b0, d_orig = 1'b0, eop = 1'b0;
    logic       decode_clear, timer_enable, rcving, pid_valid, rx_data_valid;
    logic       packet_done, r_error;
    logic [3:0] rx_pid;
    logic [7:0] rx_data;

    int n_checks = 0, n_errors = 0;
    int n_pid = 0, n_data = 0, n_done = 0;
    logic [7:0] data_q[$];
    int tb_ones = 0;
    int b_pid, b_data, b_done;

    usb_rx_sequencer #(.MAX_BYTES(4)) dut (
        .clk(clk), .rst(rst), .d_edge(d_edge), .shift_enable(shift_enable),
        .d_orig(d_orig), .eop(eop), .decode_clear(decode_clear),
        .timer_enable(timer_enable), .rcving(rcving), .rx_pid(rx_pid),
        .pid_valid(pid_valid), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .packet_done(packet_done), .r_error(r_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pid_valid) n_pid++;
        if (rx_data_valid) begin
            n_data++;
            data_q.push_back(rx_data);
        end
        if (packet_done) n_done++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        d_edge = 0; shift_enable = 0; eop = 0;
        @(negedge clk) rst = 1'b0;
        b_pid = n_pid; b_data = n_data; b_done = n_done;
    endtask

    task automatic raw_bit(input logic b);
        @(negedge clk) begin shift_enable = 1'b1; d_orig = b; end
        @(negedge clk) shift_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic stuffed_bit(input logic b);
        raw_bit(b);
        tb_ones = b ? tb_ones + 1 : 0;
        if (tb_ones == 6) begin
            raw_bit(1'b0);
            tb_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) stuffed_bit(v[i]);
    endtask

    task automatic start_pkt();
        tb_ones = 0;
        @(negedge clk) d_edge = 1'b1;
        @(negedge clk) d_edge = 1'b0;
    endtask

    task automatic send_eop();
        @(negedge clk) eop = 1'b1;
        idle(5);
        @(negedge clk) eop = 1'b0;
        idle(3);
    endtask

    initial begin
        idle(2);
        do_reset();
        check_val("rst_decode_clear", decode_clear, 1);
        check_val("rst_timer_enable", timer_enable, 0);
        check_val("rst_rcving", rcving, 0);
        check_val("rst_rx_pid", rx_pid, 0);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_strobes", {pid_valid, rx_data_valid, packet_done}, 0);
        check_val("rst_r_error", r_error, 0);

        // Good DATA0 packet, 0xFF needs a stuffed zero
        start_pkt();
        check_val("good_rcving_1cyc", rcving, 1);
        check_val("good_decode_clear", decode_clear, 0);
        send_byte(8'h80); send_byte(8'hC3);
        check_val("good_pid_cnt", n_pid - b_pid, 1);
        check_val("good_rx_pid", rx_pid, 4'h3);
        send_byte(8'h01); send_byte(8'hFF);
        send_eop();
        check_val("good_data_cnt", n_data - b_data, 2);
        if (data_q.size() >= b_data + 2) begin
            check_val("good_data0", data_q[b_data], 8'h01);
            check_val("good_data1", data_q[b_data+1], 8'hFF);
        end else check_val("good_data_q_size", data_q.size(), b_data + 2);
        check_val("good_done_cnt", n_done - b_done, 1);
        check_val("good_r_error", r_error, 0);
        check_val("good_idle_decode_clear", decode_clear, 1);

        // Bad SYNC
        do_reset();
        start_pkt();
        send_byte(8'h81);
        check_val("badsync_r_error", r_error, 1);
        check_val("badsync_rcving", rcving, 0);
        send_byte(8'hC3);
        send_eop();
        check_val("badsync_pid_cnt", n_pid - b_pid, 0);
        check_val("badsync_idle_r_error", r_error, 1);
        check_val("badsync_idle_decode_clear", decode_clear, 1);
        start_pkt();
        check_val("badsync_clr_r_error", r_error, 0);
        check_val("badsync_clr_rcving", rcving, 1);

        // Seven ones in data
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hC3); send_byte(8'h00);
        for (int i = 0; i < 7; i++) raw_bit(1'b1);
        check_val("stuff_r_error", r_error, 1);
        send_byte(8'h55);
        send_eop();
        check_val("stuff_data_cnt", n_data - b_data, 1);
        check_val("stuff_done_cnt", n_done - b_done, 0);

        // EOP after 4 bits of a data byte
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hC3); send_byte(8'h5A);
        for (int i = 0; i < 4; i++) stuffed_bit(i[0]);
        send_eop();
        check_val("eop4_r_error", r_error, 1);
        check_val("eop4_done_cnt", n_done - b_done, 0);
        check_val("eop4_data_cnt", n_data - b_data, 1);
        check_val("eop4_rx_data", rx_data, 8'h5A);

        // Strobe coinciding with eop on the 8th bit is dropped
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hC3);
        for (int i = 0; i < 7; i++) stuffed_bit(1'b0);
        @(negedge clk) begin eop = 1'b1; shift_enable = 1'b1; d_orig = 1'b0; end
        @(negedge clk) shift_enable = 1'b0;
        idle(4);
        @(negedge clk) eop = 1'b0;
        idle(3);
        check_val("eopbit_data_cnt", n_data - b_data, 0);
        check_val("eopbit_r_error", r_error, 1);
        check_val("eopbit_done_cnt", n_done - b_done, 0);

        // PID with mismatched complement
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hB3);
`ifdef USB_RX_PID_CHECK_EN
        check_val("pidchk_r_error", r_error, 1);
        check_val("pidchk_pid_cnt", n_pid - b_pid, 0);
`else
        check_val("pidnochk_r_error", r_error, 0);
        check_val("pidnochk_pid_cnt", n_pid - b_pid, 1);
        check_val("pidnochk_rx_pid", rx_pid, 4'h3);
`endif
        send_eop();

        // Reset during third data byte
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hC3); send_byte(8'h11); send_byte(8'h22);
        for (int i = 0; i < 4; i++) stuffed_bit(1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_val("midrst_rcving", rcving, 0);
        check_val("midrst_decode_clear", decode_clear, 1);
        check_val("midrst_rx_data", rx_data, 0);
        for (int i = 0; i < 4; i++) raw_bit(1'b0);
        check_val("midrst_data_cnt", n_data - b_data, 2);

        // MAX_BYTES boundary: exactly 4 bytes is clean
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hC3);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 8'hA0));
        send_eop();
        check_val("max4_data_cnt", n_data - b_data, 4);
        check_val("max4_done_cnt", n_done - b_done, 1);
        check_val("max4_r_error", r_error, 0);

        // A fifth byte overflows with no strobe
        do_reset();
        start_pkt();
        send_byte(8'h80); send_byte(8'hC3);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h10));
        send_eop();
        check_val("max5_data_cnt", n_data - b_data, 4);
        check_val("max5_r_error", r_error, 1);
        check_val("max5_done_cnt", n_done - b_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_sequencer.md
# usb_rx_sequencer

Receive-side controller for the USB 1.1 full-speed packet path. It sequences the NRZI decoder: it drives the decoder's clear, consumes the decoded bit stream on each bit strobe, removes stuffed bits, and validates SYNC and PID. It assembles LSB-first bytes, reports them to the RX FIFO and detects packet-level errors. It sits between the edge detector, bit timer and EOP detector upstream and the RX FIFO/protocol FSM downstream.

## Interface
Parameters:
- `MAX_BYTES`, default 64: maximum data bytes per packet after the PID; exceeding it is an error.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_edge`  in  1  one-cycle pulse, first transition on D+ (packet start).
- `shift_enable`  in  1  one-cycle bit strobe from bit timer; never asserted in consecutive cycles.
- `d_orig`  in  1  decoded (NRZI-removed) bit, valid when `shift_enable`=1.
- `eop`  in  1  level, SE0 currently detected.
- `decode_clear`  out  1  clear to decoder (forces previous line value to J).
- `timer_enable`  out  1  enables bit timer.
- `rcving`  out  1  packet reception in progress.
- `rx_pid`  out  4  received PID, held until next PID.
- `pid_valid`  out  1  one-cycle strobe, `rx_pid` updated.
- `rx_data`  out  8  received data byte, held until next byte.
- `rx_data_valid`  out  1  one-cycle strobe per data byte.
- `packet_done`  out  1  one-cycle strobe on clean EOP.
- `r_error`  out  1  sticky error flag, cleared on next `d_edge` accepted in IDLE.

## Operation
- States: IDLE, SYNC, PID, DATA, EOP_WAIT, ERR_WAIT.
- IDLE: `decode_clear`=1. When `d_edge`=1, go to SYNC, clear the shift register, bit counter, ones counter and byte counter, and clear `r_error`.
- Bit acceptance, in SYNC/PID/DATA on `shift_enable`=1 and `eop`=0:
  - If the ones count is 6, the bit is a stuff bit. `d_orig`=0 discards it and resets the count. `d_orig`=1 is a stuff error and goes to ERR_WAIT.
  - Otherwise shift in with `sr <= {d_orig, sr[7:1]}`, increment the 3-bit bit counter (wraps 7 to 0), and set the ones count to count+1 if `d_orig`=1, else 0.
- SYNC: on the 8th bit, `sr`==8'h80 goes to PID; anything else goes to ERR_WAIT.
- PID: on the 8th bit, `rx_pid` = `sr[3:0]`, pulse `pid_valid`, go to DATA (subject to Configuration).
- DATA: on each 8th bit, `rx_data` = `sr`, pulse `rx_data_valid`, increment the byte counter. If the byte counter reaches `MAX_BYTES` and a further byte completes, go to ERR_WAIT with no strobe for that byte.
- `eop`=1:
  - In DATA with bit counter==0: go to EOP_WAIT.
  - In DATA with bit counter≠0, or in SYNC or PID: go to ERR_WAIT.
- EOP_WAIT: when `eop` falls, pulse `packet_done` and go to IDLE.
- ERR_WAIT: `r_error`=1. Wait for `eop`=1, then for `eop`=0, then go to IDLE. `r_error` stays set in IDLE.
- Combinational outputs:
  - `decode_clear`=1 in IDLE, EOP_WAIT and ERR_WAIT.
  - `timer_enable`=1 and `rcving`=1 in SYNC, PID and DATA.
- Priority when events coincide: `rst` > `eop` > `shift_enable`. A strobe in the same cycle as `eop`=1 is ignored.
- `d_edge` outside IDLE is ignored.

## Timing
- Reset: state IDLE, `decode_clear`=1, `timer_enable`=0, `rcving`=0, `rx_pid`=0, `rx_data`=0, all strobes 0, `r_error`=0.
- Reset mid-packet: IDLE on the next edge, partial byte dropped, no strobe emitted.
- `pid_valid`, `rx_data_valid` and `packet_done` assert exactly one cycle, the cycle after the triggering edge. Data is stable while the strobe is high.
- `d_edge` to `rcving`=1: 1 cycle.
- State transitions are registered; no output depends combinationally on inputs.

## Configuration
- `USB_RX_PID_CHECK_EN` defined: on PID completion, `sr[7:4]` must equal `~sr[3:0]`. On mismatch, go to ERR_WAIT with no `pid_valid`.
- `USB_RX_PID_CHECK_EN` not defined: the upper nibble is ignored and every PID is accepted.

## Structure
- Package `usb_rx_pkg`:
  - state enum `rx_state_t`
  - `SYNC_BYTE`=8'h80
  - `STUFF_LIMIT`=6
  - `BYTE_BITS`=8
- Sub-module `usb_rx_unstuff`: ones counter plus stuff-bit/stuff-error detection. Outputs `bit_take` and `stuff_err` per strobe.

## Test plan
- Packet with SYNC 8'h80, PID DATA0 8'hC3, data 8'h01, 8'hFF, clean EOP:
  - `pid_valid` with `rx_pid`=4'h3
  - two `rx_data_valid` with 8'h01 then 8'hFF; the 8'hFF needs a stuffed 0 after six 1s
  - one `packet_done`, `r_error`=0
- SYNC received as 8'h81: ERR_WAIT, `r_error`=1, no `pid_valid`. `r_error` stays 1 through IDLE and clears on the next `d_edge`.
- Seven consecutive 1s in data: stuff error, `r_error`=1, no further `rx_data_valid`.
- EOP after 4 bits of a data byte: `r_error`=1, no `packet_done`. Also check that `eop` and `shift_enable` in the same cycle drops the bit.
- PID 8'hB3 (mismatched complement): with `USB_RX_PID_CHECK_EN`, `r_error`=1; without it, `rx_pid`=4'h3 and `pid_valid` pulses.
- `rst` asserted during the 3rd data byte: next cycle in IDLE with `rcving`=0 and `decode_clear`=1, and no strobe for the partial byte.
